// File: rtl/grn_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Package  : grn_pkg                                                    |
// | Purpose  : Shared constants and helpers for the GRN node LUT block.   |
// |            Holds default geometry, a constant clog2 and the helper    |
// |            that locates copy c's slice inside the packed input bus.   |
// | Revision : 1.0  initial release                                       |
// +-----------------------------------------------------------------------+
package grn_pkg;

  localparam int DEF_NUM_IN   = 5;
  localparam int DEF_NUM_COPY = 2;
  localparam int DEF_DIV_W    = 4;

  // Ceiling log2 for elaboration-time sizing (returns 0 for v <= 1).
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

  // Copy c owns in_s[in_base(c, n) +: n]; bit i of that slice is LUT address bit i.
  function automatic int in_base(input int c, input int n);
    return c * n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/grn_copy_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : grn_copy_ctrl                                              |
// | Purpose  : One state copy of a GRN node: state bit, update-divisor    |
// |            register, phase counter and state-change pulse.           |
// | Ports    : clk, rst_n      clock / sync active-low reset              |
// |            reset_nos_i     load init_i, clear phase                   |
// |            init_i          initial state for reset_nos_i              |
// |            start_i         evaluation strobe                          |
// |            lut_val_i       LUT output for this copy's input vector    |
// |            div_we_i        divisor write (already decoded per copy)   |
// |            div_val_i       divisor value                              |
// |            s_o             registered state                           |
// |            changed_o       one-cycle pulse on a toggling update       |
// | Revision : 1.0  initial release                                       |
// +-----------------------------------------------------------------------+
module grn_copy_ctrl
  import grn_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             reset_nos_i,
  input  logic             init_i,
  input  logic             start_i,
  input  logic             lut_val_i,
  input  logic             div_we_i,
  input  logic [DIV_W-1:0] div_val_i,
  output logic             s_o,
  output logic             changed_o
);

  logic             s_q, s_d;
  logic             changed_q, changed_d;
  logic [DIV_W-1:0] phase_q, phase_d;
  logic [DIV_W-1:0] div_q, div_d;

  always_comb begin
    s_d       = s_q;
    phase_d   = phase_q;
    changed_d = 1'b0;
    // A divisor write never touches the phase; an update in the same
    // cycle reloads from div_q, i.e. the old divisor.
    div_d     = div_we_i ? div_val_i : div_q;

    if (reset_nos_i) begin
      s_d     = init_i;
      phase_d = '0;
    end else if (start_i) begin
      if (phase_q == '0) begin
        s_d       = lut_val_i;
        phase_d   = div_q;
        changed_d = (lut_val_i != s_q);
      end else begin
        phase_d = phase_q - DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_q       <= 1'b0;
      changed_q <= 1'b0;
      phase_q   <= '0;
      div_q     <= '0;
    end else begin
      s_q       <= s_d;
      changed_q <= changed_d;
      phase_q   <= phase_d;
      div_q     <= div_d;
    end
  end

  assign s_o       = s_q;
  assign changed_o = changed_q;

endmodule
`default_nettype wire

// File: rtl/grn_node_lut.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : grn_node_lut                                               |
// | Purpose  : Gene-regulatory-network node with NUM_COPY independent     |
// |            state copies, each updated from a shared runtime-          |
// |            programmable 2^NUM_IN-bit truth table.                     |
// | Ports    : clk, rst_n          clock / sync active-low reset          |
// |            reset_nos_i         load init_state_i, restart phases      |
// |            init_state_i        per-copy initial state                 |
// |            start_s_i           per-copy evaluation strobe             |
// |            in_s_i              packed per-copy input vectors          |
// |            cfg_we_i/addr/data  LUT bit write port                     |
// |            div_we_i/sel/val    per-copy divisor write port            |
// |            s_o                 registered state per copy              |
// |            changed_o           per-copy state-change pulse            |
// | Revision : 1.0  initial release                                       |
// +-----------------------------------------------------------------------+
module grn_node_lut
  import grn_pkg::*;
#(
  parameter int NUM_IN   = DEF_NUM_IN,
  parameter int NUM_COPY = DEF_NUM_COPY,
  parameter int DIV_W    = DEF_DIV_W,
  parameter int SEL_W    = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       reset_nos_i,
  input  logic [NUM_COPY-1:0]        init_state_i,
  input  logic [NUM_COPY-1:0]        start_s_i,
  input  logic [NUM_COPY*NUM_IN-1:0] in_s_i,
  input  logic                       cfg_we_i,
  input  logic [NUM_IN-1:0]          cfg_addr_i,
  input  logic                       cfg_data_i,
  input  logic                       div_we_i,
  input  logic [SEL_W-1:0]           div_sel_i,
  input  logic [DIV_W-1:0]           div_val_i,
  output logic [NUM_COPY-1:0]        s_o,
  output logic [NUM_COPY-1:0]        changed_o
);

  localparam int LUT_DEPTH = 1 << NUM_IN;

  // Shared truth table; all copies read it combinationally, so a write in
  // the same cycle as an evaluation is only seen from the next cycle on.
  logic [LUT_DEPTH-1:0] lut_q, lut_d;

  always_comb begin
    lut_d = lut_q;
    if (cfg_we_i) lut_d[cfg_addr_i] = cfg_data_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) lut_q <= '0;
    else        lut_q <= lut_d;
  end

  genvar c;
  generate
    for (c = 0; c < NUM_COPY; c = c + 1) begin : g_copy
      logic lut_bit;
      logic copy_div_we;

      assign lut_bit     = lut_q[in_s_i[in_base(c, NUM_IN) +: NUM_IN]];
      // Out-of-range selects match no copy and are dropped.
      assign copy_div_we = div_we_i && (div_sel_i == SEL_W'(c));

      grn_copy_ctrl #(
        .DIV_W (DIV_W)
      ) u_copy (
        .clk         (clk),
        .rst_n       (rst_n),
        .reset_nos_i (reset_nos_i),
        .init_i      (init_state_i[c]),
        .start_i     (start_s_i[c]),
        .lut_val_i   (lut_bit),
        .div_we_i    (copy_div_we),
        .div_val_i   (div_val_i),
        .s_o         (s_o[c]),
        .changed_o   (changed_o[c])
      );
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_grn_node_lut.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : tb_grn_node_lut                                            |
// | Purpose  : Self-checking bench for grn_node_lut against a start-count |
// |            reference model of LUT evaluation and divided updates.    |
// | Revision : 1.0  initial release                                       |
// +-----------------------------------------------------------------------+
module tb_grn_node_lut;

  localparam int NI = 5;
  localparam int NC = 2;
  localparam int DW = 4;
  localparam int SW = 1;

  logic           clk;
  logic           rst_n;
  logic           reset_nos;
  logic [NC-1:0]  init_state;
  logic [NC-1:0]  start_s;
  logic [NC*NI-1:0] in_s;
  logic           cfg_we;
  logic [NI-1:0]  cfg_addr;
  logic           cfg_data;
  logic           div_we;
  logic [SW-1:0]  div_sel;
  logic [DW-1:0]  div_val;
  logic [NC-1:0]  s;
  logic [NC-1:0]  changed;

  grn_node_lut #(
    .NUM_IN   (NI),
    .NUM_COPY (NC),
    .DIV_W    (DW),
    .SEL_W    (SW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .reset_nos_i  (reset_nos),
    .init_state_i (init_state),
    .start_s_i    (start_s),
    .in_s_i       (in_s),
    .cfg_we_i     (cfg_we),
    .cfg_addr_i   (cfg_addr),
    .cfg_data_i   (cfg_data),
    .div_we_i     (div_we),
    .div_sel_i    (div_sel),
    .div_val_i    (div_val),
    .s_o          (s),
    .changed_o    (changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a copy updates on start number k (counted from 0 since
  // reset_nos/reset) when k equals the scheduled index; each update
  // schedules the next one D+1 starts later, D being the divisor then held.
  logic          lut_m [32];
  logic [DW-1:0] div_m [NC];
  int            scnt  [NC];
  int            nupd  [NC];
  logic [NC-1:0] s_m;
  logic [NC-1:0] ch_m;

  int errors;
  int checks;

  task automatic model_step();
    logic nv;
    if (!rst_n) begin
      s_m  = '0;
      ch_m = '0;
      for (int a = 0; a < 32; a++) lut_m[a] = 1'b0;
      for (int c = 0; c < NC; c++) begin
        div_m[c] = '0; scnt[c] = 0; nupd[c] = 0;
      end
    end else begin
      for (int c = 0; c < NC; c++) begin
        ch_m[c] = 1'b0;
        if (reset_nos) begin
          s_m[c]  = init_state[c];
          scnt[c] = 0;
          nupd[c] = 0;
        end else if (start_s[c]) begin
          if (scnt[c] == nupd[c]) begin
            nv      = lut_m[int'(in_s[c*NI +: NI])];
            ch_m[c] = (nv != s_m[c]);
            s_m[c]  = nv;
            nupd[c] = scnt[c] + int'(div_m[c]) + 1;
          end
          scnt[c] = scnt[c] + 1;
        end
      end
      if (cfg_we) lut_m[int'(cfg_addr)] = cfg_data;
      if (div_we && int'(div_sel) < NC) div_m[int'(div_sel)] = div_val;
    end
  endtask

  task automatic check(input string tag);
    checks++;
    assert (s === s_m) else begin
      errors++;
      $error("FAIL %s s: observed=%b expected=%b", tag, s, s_m);
    end
    checks++;
    assert (changed === ch_m) else begin
      errors++;
      $error("FAIL %s changed: observed=%b expected=%b", tag, changed, ch_m);
    end
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check(tag);
  endtask

  task automatic clr();
    reset_nos = 1'b0; start_s = '0; cfg_we = 1'b0; div_we = 1'b0;
  endtask

  task automatic lut_wr(input int a, input logic v);
    cfg_we = 1'b1; cfg_addr = NI'(a); cfg_data = v;
    tick("lut_wr");
    clr();
  endtask

  task automatic div_wr(input int c, input int v);
    div_we = 1'b1; div_sel = SW'(c); div_val = DW'(v);
    tick("div_wr");
    clr();
  endtask

  task automatic go(input logic [NC-1:0] st, input int a0, input int a1, input string tag);
    start_s = st; in_s = {NI'(a1), NI'(a0)};
    tick(tag);
    clr();
  endtask

  initial begin
    errors = 0; checks = 0;
    rst_n = 1'b1; clr();
    init_state = '0; in_s = '0; cfg_addr = '0; cfg_data = 1'b0;
    div_sel = '0; div_val = '0;
    @(posedge clk); #1;

    // Reset with random inputs on all other ports
    for (int k = 0; k < 2; k++) begin
      rst_n = 1'b0;
      reset_nos = 1'($urandom); init_state = NC'($urandom); start_s = NC'($urandom);
      in_s = (NC*NI)'($urandom); cfg_we = 1'($urandom); cfg_addr = NI'($urandom);
      cfg_data = 1'($urandom); div_we = 1'($urandom); div_sel = SW'($urandom);
      div_val = DW'($urandom);
      tick("reset");
    end
    rst_n = 1'b1; clr();

    // LUT cleared: every address reads 0 through D=0 updates
    for (int a = 0; a < 32; a++) go(2'b11, a, 31 - a, "lut_clear");

    // f = (in0|in1)&in2&in3&in4
    lut_wr(29, 1'b1); lut_wr(30, 1'b1); lut_wr(31, 1'b1);
    go(2'b01, 5'b11101, 0, "lut_f_hi");
    go(2'b01, 5'b11100, 0, "lut_f_lo");

    // Divisor: copy0 D=1, copy1 D=0
    div_wr(0, 1); div_wr(1, 0);
    reset_nos = 1'b1; init_state = 2'b00; tick("nos"); clr();
    for (int k = 0; k < 4; k++) go(2'b11, 29, 29, "div_same");
    reset_nos = 1'b1; init_state = 2'b00; tick("nos2"); clr();
    for (int k = 0; k < 6; k++)
      go(2'b11, (k % 2 == 0) ? 29 : 0, (k % 2 == 0) ? 29 : 0, "div_toggle");

    // Priority: reset_nos beats start; rst_n beats reset_nos
    go(2'b11, 29, 29, "pre_prio");
    reset_nos = 1'b1; init_state = 2'b10; start_s = 2'b11; in_s = {5'd29, 5'd29};
    tick("prio_nos"); clr();
    go(2'b11, 29, 29, "prio_phase0");
    rst_n = 1'b0; reset_nos = 1'b1; init_state = 2'b11; tick("prio_rst"); clr();
    rst_n = 1'b1;

    // Same-cycle LUT write: evaluation sees the old bit
    cfg_we = 1'b1; cfg_addr = 5'd31; cfg_data = 1'b1;
    go(2'b01, 31, 0, "lut_same_old");
    go(2'b01, 31, 0, "lut_same_new");

    // Same-cycle divisor write: update reloads the old D=0
    div_we = 1'b1; div_sel = 1'b0; div_val = 4'd3;
    go(2'b01, 0, 0, "div_same_cyc");
    for (int k = 0; k < 10; k++)
      go(2'b01, (k % 2 == 0) ? 31 : 0, 0, "div_spacing");

    // Randomised traffic
    for (int k = 0; k < 400; k++) begin
      rst_n      = ($urandom_range(0, 99) != 0);
      reset_nos  = ($urandom_range(0, 19) == 0);
      init_state = NC'($urandom);
      start_s    = NC'($urandom);
      in_s       = (NC*NI)'($urandom);
      cfg_we     = ($urandom_range(0, 2) == 0);
      cfg_addr   = NI'($urandom);
      cfg_data   = 1'($urandom);
      div_we     = ($urandom_range(0, 7) == 0);
      div_sel    = SW'($urandom);
      div_val    = DW'($urandom_range(0, 3));
      tick("random");
    end
    rst_n = 1'b1; clr();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/grn_node_lut.md
Name: grn_node_lut

Overview:
- Parametrised gene-regulatory-network node for the GNR accelerator.
- Holds NUM_COPY independent boolean state copies (e.g. synchronous and asynchronous simulation streams) of one network node.
- Each copy's next state is a runtime-programmable NUM_IN-input truth table (LUT) of that copy's input vector, instead of a hard-wired expression.
- Each copy has a programmable update divisor (the two-phase skip generalised to any period) and a per-copy state-change pulse used by the steady-state detector.

Parameters:
- NUM_IN, 5, inputs per node; LUT depth is 2^NUM_IN bits.
- NUM_COPY, 2, independent state copies.
- DIV_W, 4, width of update-divisor and phase counters.
- SEL_W, 1, width of div_sel; must be ≥ max(1, clog2(NUM_COPY)).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- reset_nos  in  1  load init_state into all copies, restart phases.
- init_state  in  NUM_COPY  per-copy initial state for reset_nos.
- start_s  in  NUM_COPY  per-copy evaluation strobe.
- in_s  in  NUM_COPY*NUM_IN  input vectors; copy c uses bits [c*NUM_IN +: NUM_IN], bit i = LUT address bit i.
- cfg_we  in  1  LUT bit write enable.
- cfg_addr  in  NUM_IN  LUT bit address.
- cfg_data  in  1  LUT bit value.
- div_we  in  1  divisor write enable.
- div_sel  in  SEL_W  copy index for divisor write.
- div_val  in  DIV_W  divisor value D (0 means update on every start).
- s  out  NUM_COPY  registered node state per copy.
- changed  out  NUM_COPY  one-cycle pulse when copy c's state toggles on an update.

Behaviour:
- Reset (rst_n=0 at a clock edge): s=0, changed=0, every LUT bit=0, every divisor=0, every phase=0. Reset overrides all other inputs. Reset mid-run discards LUT and divisor contents.
- Priority per copy: rst_n, then reset_nos, then start_s[c].
- reset_nos=1: s[c]<=init_state[c]; phase[c]<=0; changed[c]<=0. start_s is ignored in that cycle.
- start_s[c]=1 with phase[c]==0 (update cycle):
  - s[c]<=lut[in_s copy c], so the result is visible the cycle after start.
  - phase[c]<=div[c].
  - changed[c]<=(new value != s[c]).
- start_s[c]=1 with phase[c]!=0 (skip cycle): s[c] holds; phase[c]<=phase[c]-1; changed[c]<=0.
- start_s[c]=0: s[c] and phase[c] hold; changed[c]<=0.
- Update rate: with D=div[c], a copy updates on the 1st, (D+2)th, (2D+3)th, ... start after reset_nos. D=1 gives the alternate-start update; D=0 gives an update on every start.
- LUT write: cfg_we=1 sets lut[cfg_addr]<=cfg_data. It is not gated by reset_nos. An evaluation in the same cycle reads the old LUT contents.
- Divisor write: div_we=1 sets div[div_sel]<=div_val. div_sel ≥ NUM_COPY is ignored.
  - The current phase is not altered; the new value applies at the next reload.
  - A same-cycle update reloads phase with the old divisor.
- Copies are fully independent; simultaneous starts on several copies are all served in the same cycle.
- changed is registered and is never high for more than one consecutive cycle unless consecutive updates both toggle.

Decomposition:
- Shared package grn_pkg: clog2 constant function, default NUM_IN/NUM_COPY/DIV_W, and the index-slicing convention for in_s.
- The LUT register file stays in the top module because it is shared by all copies.
- One sub-module, grn_copy_ctrl: per-copy state register, phase counter, divisor register and changed pulse. Instantiate it NUM_COPY times with a generate loop.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with random inputs -> s=0, changed=0; reading the LUT via D=0 updates gives 0 for all 32 addresses.
- LUT function: program f=(in0|in1)&in2&in3&in4 (lut[29]=lut[30]=lut[31]=1, all others 0), D=0. Apply start with in_s copy0=5'b11101 -> s[0]=1 and changed[0]=1 next cycle. Then apply in_s=5'b11100 -> s[0]=0.
- Divisor: D=1 on copy0, D=0 on copy1, reset_nos with init 2'b00, same satisfying input, 4 starts -> copy0 updates on starts 1 and 3, copy1 on all 4. With toggling inputs, changed matches the updated starts only.
- Priority: assert reset_nos and start_s=2'b11 together with init_state=2'b10 -> s=2'b10, changed=0, phases 0. Assert rst_n=0 together with reset_nos -> s=0.
- Same-cycle LUT write: lut[31] currently 0; write lut[31]=1 while start with input 31 -> s=0. The next start -> s=1, changed=1.
- Same-cycle divisor write: div[0] 0->3 during an update -> the next start also updates (old D=0 reload). The following updates are spaced 4 starts apart.
